data_memory_responder: RTL and testbench



---
 rtl/data_memory_responder_pkg.sv | 21 ++
 rtl/data_memory_array.sv | 41 ++++
 rtl/data_memory_responder.sv | 150 +++++++++++++++
 tb/tb_data_memory_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_memory_responder_pkg
// Shared constants and types for the off-chip data memory model.
//   LINE_W          : width of one cache line in bits
//   OFFSET_BITS     : byte-offset bits within a line (ignored by the memory)
//   DEFAULT_LATENCY : default request-to-acknowledge latency in cycles
//   state_t         : controller state encoding (IDLE / WAIT / ACK)
// -----------------------------------------------------------------------------
package data_memory_responder_pkg;

  localparam int LINE_W          = 256;
  localparam int OFFSET_BITS     = 5;
  localparam int DEFAULT_LATENCY = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/data_memory_array.sv
// -----------------------------------------------------------------------------
// data_memory_array
// Single-port synchronous line RAM, DEPTH x LINE_W, no reset.
// Ports:
//   clk        : clock
//   index      : line index for both read and write
//   write_en   : write write_data into the indexed line at the clock edge
//   write_data : line to be written
//   read_en    : capture the indexed line into read_data at the clock edge
//   read_data  : registered read line, held until the next read
// -----------------------------------------------------------------------------
module data_memory_array #(
  parameter int LINE_W = 256,
  parameter int DEPTH  = 512,
  parameter int IDX_W  = 9
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  index,
  input  logic              write_en,
  input  logic [LINE_W-1:0] write_data,
  input  logic              read_en,
  output logic [LINE_W-1:0] read_data
);

  import data_memory_responder_pkg::*;

  logic [LINE_W-1:0] mem [DEPTH];

  // The array is never reset; its contents survive a controller reset.
  // Read and write share one index, and the controller never asks for both
  // in the same cycle.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[index] <= write_data;
    end
    if (read_en) begin
      read_data <= mem[index];
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// -----------------------------------------------------------------------------
// data_memory_responder
// Off-chip data memory model answering 256-bit line requests from the data
// cache. One request is accepted at a time, held for LATENCY cycles, then
// completed with a one-cycle acknowledge.
// Ports:
//   clk_i    : clock
//   rst_i    : synchronous active-high reset (memory contents are kept)
//   addr_i   : byte address of the request, bits [4:0] ignored
//   data_i   : write line
//   enable_i : request valid
//   write_i  : 1 = write, 0 = read
//   ack_o    : one-cycle completion pulse
//   data_o   : read line, valid in the ack cycle and held until the next read
//   busy_o   : a request is in flight
// -----------------------------------------------------------------------------
module data_memory_responder #(
  parameter int LINE_W  = data_memory_responder_pkg::LINE_W,
  parameter int DEPTH   = 512,
  parameter int IDX_W   = 9,
  parameter int LATENCY = data_memory_responder_pkg::DEFAULT_LATENCY
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o
);

  import data_memory_responder_pkg::*;

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  next_count;
  logic [IDX_W-1:0]  req_index;
  logic [IDX_W-1:0]  idx_q;
  logic              wr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] line_q;
  logic              read_req;
  logic [IDX_W-1:0]  ram_index;
  logic              ram_we;
  logic              ram_re;
  logic [LINE_W-1:0] ram_rdata;
  logic              unused_addr_bits;

  // Only the line-index bits select a line, so addresses beyond DEPTH lines
  // wrap and misaligned addresses behave as aligned ones.
  assign req_index        = addr_i[IDX_W+OFFSET_BITS-1:OFFSET_BITS];
  assign unused_addr_bits = ^{addr_i[31:IDX_W+OFFSET_BITS], addr_i[OFFSET_BITS-1:0]};

  // State, countdown and request latches. Request fields are captured only
  // at acceptance, so later changes to the inputs cannot affect an access.
  // line_q holds the last read line so data_o survives after the ack cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      count   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      line_q  <= '0;
    end else begin
      state <= next_state;
      count <= next_count;
      if (state == IDLE && enable_i) begin
        idx_q   <= req_index;
        wr_q    <= write_i;
        wdata_q <= data_i;
      end
      if (state == ACK && !wr_q) begin
        line_q <= ram_rdata;
      end
    end
  end

  // The countdown enters ACK on the same edge it reaches zero, so the ack
  // cycle begins LATENCY-1 edges after acceptance; with LATENCY=1 the block
  // jumps straight from IDLE to ACK. The RAM read is launched on the edge
  // that enters ACK so the line is registered for the ack cycle.
  always_comb begin
    next_state = state;
    next_count = count;
    read_req   = 1'b0;
    case (state)
      IDLE: begin
        if (enable_i) begin
          if (LATENCY == 1) begin
            next_state = ACK;
            next_count = '0;
            read_req   = !write_i;
          end else begin
            next_state = WAIT;
            next_count = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (count <= CNT_W'(1)) begin
          next_state = ACK;
          next_count = '0;
          read_req   = !wr_q;
        end else begin
          next_count = count - CNT_W'(1);
        end
      end
      ACK: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
        next_count = '0;
      end
    endcase
  end

  // In IDLE the index comes straight from the address so the LATENCY=1
  // read can be launched on the acceptance edge. Reset suppresses both RAM
  // strobes so an interrupted write never lands, even at the ACK closing edge.
  assign ram_index = (state == IDLE) ? req_index : idx_q;
  assign ram_we    = (state == ACK) && wr_q && !rst_i;
  assign ram_re    = read_req && !rst_i;

  data_memory_array #(
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk        (clk_i),
    .index      (ram_index),
    .write_en   (ram_we),
    .write_data (wdata_q),
    .read_en    (ram_re),
    .read_data  (ram_rdata)
  );

  // Read data is shown live from the RAM register during a read ack and
  // from the holding register otherwise; write acks leave data_o untouched.
  assign ack_o  = (state == ACK);
  assign busy_o = (state != IDLE);
  assign data_o = (state == ACK && !wr_q) ? ram_rdata : line_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_data_memory_responder
// Self-checking bench: a LATENCY=10 instance checked through a scoreboard of
// expected acks (cycle and data_o), plus a LATENCY=1 instance for the
// wrap / single-cycle-latency configuration.
// -----------------------------------------------------------------------------
module tb_data_memory_responder;

  localparam int LAT    = 10;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       addr = '0;
  logic [LINE_W-1:0] wdata = '0;
  logic              enable = 1'b0;
  logic              write = 1'b0;
  logic              ack;
  logic [LINE_W-1:0] data_out;
  logic              busy;

  logic [31:0]       addr1 = '0;
  logic [LINE_W-1:0] wdata1 = '0;
  logic              enable1 = 1'b0;
  logic              write1 = 1'b0;
  logic              ack1;
  logic [LINE_W-1:0] data_out1;
  logic              busy1;

  typedef struct {
    logic [LINE_W-1:0] data;
    int                cyc;
    int                id;
  } exp_t;

  exp_t              sb[$];
  exp_t              mon_e;
  logic [LINE_W-1:0] model_mem [int];
  logic [LINE_W-1:0] last_read = '0;
  int                free_at = 0;
  int                next_id = 0;
  int                cyc = 0;
  int                compare_count = 0;
  int                mismatch_count = 0;

  logic [LINE_W-1:0] pat_a5 = {32{8'hA5}};
  logic [LINE_W-1:0] pat_5a = {32{8'h5A}};
  logic [LINE_W-1:0] pat_p3 = {8{32'hDEADBEEF}};
  logic [LINE_W-1:0] pat_w  = {4{64'h0123456789ABCDEF}};
  logic [LINE_W-1:0] pat_c  = {16{16'hC3E1}};
  logic [LINE_W-1:0] pat_l1 = {8{32'h1234ABCD}};

  data_memory_responder #(.LATENCY(LAT)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .addr_i   (addr),
    .data_i   (wdata),
    .enable_i (enable),
    .write_i  (write),
    .ack_o    (ack),
    .data_o   (data_out),
    .busy_o   (busy)
  );

  data_memory_responder #(.LATENCY(1)) dut1 (
    .clk_i    (clk),
    .rst_i    (rst),
    .addr_i   (addr1),
    .data_i   (wdata1),
    .enable_i (enable1),
    .write_i  (write1),
    .ack_o    (ack1),
    .data_o   (data_out1),
    .busy_o   (busy1)
  );

  // Free-running clock and an edge counter used to timestamp acks.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Counts one comparison and reports it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [LINE_W-1:0] observed,
                             input logic [LINE_W-1:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Advances to just after the rising edge that brings cyc to target.
  task automatic waitUntil(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives a request and pushes its expected ack (cycle and data_o) based on
  // the model memory. Inputs may be set while the DUT is still busy; the
  // request is then accepted on the first free edge.
  task automatic applyStimulus(input logic wr, input logic [31:0] a,
                               input logic [LINE_W-1:0] d, output int acc);
    exp_t e;
    int   idx;
    acc    = (cyc + 1 > free_at) ? cyc + 1 : free_at;
    enable = 1'b1;
    write  = wr;
    addr   = a;
    wdata  = d;
    idx    = int'(a[13:5]);
    e.cyc  = acc + LAT - 1;
    e.id   = next_id;
    next_id++;
    if (wr) begin
      e.data         = last_read;
      model_mem[idx] = d;
    end else begin
      e.data    = model_mem[idx];
      last_read = e.data;
    end
    sb.push_back(e);
    free_at = e.cyc + 2;
  endtask

  // Single request: drive it, hold enable until accepted, then drop it.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [LINE_W-1:0] d);
    int acc;
    applyStimulus(wr, a, d, acc);
    waitUntil(acc);
    enable = 1'b0;
  endtask

  // Waits (bounded) for every expected ack to be seen.
  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (sb.size() != 0) checkOutput("drain_timeout", LINE_W'(sb.size()), '0);
  endtask

  // Scoreboard consumer: every ack of the main instance must match the
  // oldest expectation in cycle and data_o.
  always @(negedge clk) begin
    if (!rst && ack === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_ack", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput($sformatf("ack%0d_cycle", mon_e.id), LINE_W'(cyc), LINE_W'(mon_e.cyc));
        checkOutput($sformatf("ack%0d_data", mon_e.id), data_out, mon_e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int acc;
    int acc2;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ack", ack, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_data", data_out, 0);
    checkOutput("reset_ack_l1", ack1, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    issue(1'b1, 32'h0000_0200, pat_a5);
    issue(1'b1, 32'h0000_3FE0, pat_5a);
    issue(1'b1, 32'h0000_0060, pat_p3);

    applyStimulus(1'b0, 32'h0000_0200, '0, acc);
    waitUntil(acc);
    enable = 1'b0;
    @(negedge clk);
    checkOutput("busy_after_accept", busy, 1);
    waitUntil(acc + LAT - 1);
    @(negedge clk);
    checkOutput("busy_in_ack", busy, 1);
    waitUntil(acc + LAT);
    @(negedge clk);
    checkOutput("busy_after_ack", busy, 0);

    issue(1'b1, 32'h0000_0400, pat_w);
    issue(1'b0, 32'h0000_0400, '0);

    applyStimulus(1'b1, 32'h0000_0800, pat_c, acc);
    waitUntil(acc + LAT - 1);
    applyStimulus(1'b0, 32'h0000_0400, '0, acc2);
    waitUntil(acc2);
    enable = 1'b0;
    issue(1'b0, 32'h0000_0800, '0);

    applyStimulus(1'b0, 32'h0000_0200, '0, acc);
    waitUntil(acc + 2);
    addr   = 32'h0000_3FE0;
    write  = 1'b1;
    wdata  = '1;
    enable = 1'b0;

    issue(1'b0, 32'h0000_041F, '0);
    issue(1'b0, 32'h0000_4200, '0);
    issue(1'b0, 32'h0000_3FE0, '0);
    drain();

    acc    = (cyc + 1 > free_at) ? cyc + 1 : free_at;
    enable = 1'b1;
    write  = 1'b1;
    addr   = 32'h0000_0060;
    wdata  = '1;
    waitUntil(acc);
    enable = 1'b0;
    waitUntil(acc + 5);
    rst = 1'b1;
    waitUntil(acc + 7);
    @(negedge clk);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_data", data_out, 0);
    rst       = 1'b0;
    last_read = '0;
    free_at   = 0;
    waitUntil(acc + LAT + 4);
    issue(1'b0, 32'h0000_0060, '0);
    drain();

    enable1 = 1'b1;
    write1  = 1'b1;
    addr1   = 32'h0000_0000;
    wdata1  = pat_l1;
    acc     = cyc + 1;
    waitUntil(acc);
    enable1 = 1'b0;
    @(negedge clk);
    checkOutput("l1_write_ack", ack1, 1);
    checkOutput("l1_write_data", data_out1, 0);
    waitUntil(acc + 1);
    @(negedge clk);
    checkOutput("l1_ack_drop", ack1, 0);
    enable1 = 1'b1;
    write1  = 1'b0;
    addr1   = 32'h0000_4000;
    acc2    = cyc + 1;
    waitUntil(acc2);
    enable1 = 1'b0;
    @(negedge clk);
    checkOutput("l1_read_ack", ack1, 1);
    checkOutput("l1_read_busy", busy1, 1);
    checkOutput("l1_wrap_data", data_out1, pat_l1);
    waitUntil(acc2 + 1);
    @(negedge clk);
    checkOutput("l1_read_ack_drop", ack1, 0);
    checkOutput("l1_read_hold", data_out1, pat_l1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
